// File: rtl/mmio_bridge_pkg.sv
// Shared state encoding, command/response byte values and frame lengths
// for the UART-to-FPro MMIO debug bridge.
package mmio_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  localparam int ADDR_BYTES = 3;
  localparam int DATA_BYTES = 4;

  // Last value of the 2-bit byte counter in each frame phase.
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

  localparam logic [2:0] RD_RESP_LEN  = 3'd4;
  localparam logic [2:0] WR_RESP_LEN  = 3'd1;
  localparam logic [2:0] ERR_RESP_LEN = 3'd1;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/bridge_tx_ser.sv
// Response serializer: loads a 32-bit word and emits 1 or 4 bytes,
// most significant byte first, over a valid/ready handshake.
module bridge_tx_ser (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last
);

  logic [31:0] shift_q;
  logic [1:0]  left_q;
  logic        valid_q;
  logic        fire;

  assign fire     = valid_q && tx_ready;
  assign tx_data  = shift_q[31:24];
  assign tx_valid = valid_q;
  assign last     = fire && (left_q == 2'd0);

  // left_q holds the number of bytes still to follow the one on tx_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      left_q  <= 2'(load_count - 3'd1);
      valid_q <= 1'b1;
    end else if (fire) begin
      if (left_q == 2'd0) begin
        valid_q <= 1'b0;
      end else begin
        shift_q <= {shift_q[23:0], 8'h00};
        left_q  <= left_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/mmio_debug_bridge.sv
// UART byte-stream to FPro MMIO bridge: parses 'W'/'R' frames, issues one
// bus cycle and returns an acknowledge or the read word.
module mmio_debug_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic [20:0]        addr_q;
  logic [31:0]        data_q;
  logic               is_write_q;
  logic               overrun_q;
  logic               frame_phase;
  logic               timeout;

  logic               ser_load;
  logic [31:0]        ser_word;
  logic [2:0]         ser_count;
  logic               ser_last;

  assign frame_phase = (state_q == ST_ADDR) || (state_q == ST_DATA);
  // The frame is abandoned at the end of the TIMEOUT_CYC-th idle clock.
  assign timeout     = frame_phase && !rx_valid && (idle_cnt_q == IDLE_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      is_write_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q)
        byte_cnt_q <= '0;
      else if (rx_valid && frame_phase)
        byte_cnt_q <= byte_cnt_q + 2'd1;

      if (state_d != state_q || rx_valid)
        idle_cnt_q <= '0;
      else if (frame_phase)
        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);

      if (state_q == ST_IDLE && rx_valid)
        is_write_q <= (rx_data == CMD_WRITE);

      // Address bits above 20 simply fall off the top of the shift register.
      if (state_q == ST_ADDR && rx_valid)
        addr_q <= {addr_q[12:0], rx_data};

      if (state_q == ST_DATA && rx_valid)
        data_q <= {data_q[23:0], rx_data};

      if (rx_valid && (state_q == ST_BUS || state_q == ST_RESP))
        overrun_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ser_load  = 1'b0;
    ser_word  = '0;
    ser_count = ERR_RESP_LEN;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (is_cmd(rx_data)) begin
            state_d = ST_ADDR;
          end else begin
            state_d   = ST_RESP;
            ser_load  = 1'b1;
            ser_word  = {RSP_ERR, 24'h0};
            ser_count = ERR_RESP_LEN;
          end
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          if (byte_cnt_q == ADDR_LAST)
            state_d = is_write_q ? ST_DATA : ST_BUS;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          if (byte_cnt_q == DATA_LAST)
            state_d = ST_BUS;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // Loading here captures mmio_rd_data on the edge that closes the bus cycle.
        state_d  = ST_RESP;
        ser_load = 1'b1;
        if (is_write_q) begin
          ser_word  = {RSP_OK, 24'h0};
          ser_count = WR_RESP_LEN;
        end else begin
          ser_word  = mmio_rd_data;
          ser_count = RD_RESP_LEN;
        end
      end
      ST_RESP: begin
        if (ser_last)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bridge_tx_ser u_tx_ser (
    .clk        (clk),
    .reset      (reset),
    .load       (ser_load),
    .load_data  (ser_word),
    .load_count (ser_count),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .last       (ser_last)
  );

  assign mmio_cs      = (state_q == ST_BUS);
  assign mmio_wr      = (state_q == ST_BUS) && is_write_q;
  assign mmio_rd      = (state_q == ST_BUS) && !is_write_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = data_q;
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mmio_debug_bridge.sv
// Randomized self-checking bench for mmio_debug_bridge with a frame-level
// reference model (expected bus accesses and response bytes per frame).
module tb_mmio_debug_bridge;

  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] data;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        busy;
  logic        overrun;

  int          total = 0;
  int          bad = 0;
  int          ready_mode = 1;
  logic [31:0] rd_word = 32'h0;
  logic        prev_cs = 1'b0;

  bus_t        got_bus[$];
  bus_t        exp_bus[$];
  logic [7:0]  got_tx[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  frame[$];

  mmio_debug_bridge #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .mmio_cs      (mmio_cs),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (mmio_rd_data),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // tx_ready: 0 = held low, 1 = held high, otherwise random
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Read data is only meaningful during the read strobe; junk elsewhere
  initial begin
    mmio_rd_data = $urandom;
    forever begin
      @(negedge clk);
      mmio_rd_data = (mmio_cs && mmio_rd) ? rd_word : $urandom;
    end
  end

  // Bus and tx monitor
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      if (mmio_cs) begin
        total++;
        if (!(mmio_wr ^ mmio_rd) || prev_cs) begin
          bad++;
          $display("[TB] FAIL bus_strobe: cs=1 wr=%b rd=%b prev_cs=%b, required single cycle with one of wr/rd",
                   mmio_wr, mmio_rd, prev_cs);
        end
        b.wr   = mmio_wr;
        b.addr = mmio_addr;
        b.data = mmio_wr ? mmio_wr_data : 32'h0;
        got_bus.push_back(b);
      end else if (mmio_wr || mmio_rd) begin
        total++;
        bad++;
        $display("[TB] FAIL strobe_without_cs: wr=%b rd=%b, required 0 0", mmio_wr, mmio_rd);
      end
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      prev_cs = mmio_cs;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame[i]) begin
      if (gaps) repeat ($urandom_range(0, 3)) step();
      send_byte(frame[i]);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic clear_obs();
    got_bus.delete();
    got_tx.delete();
  endtask

  // Frame-level reference: what one frame must do on the bus and on tx
  function automatic void model_expect();
    bus_t        b;
    logic [23:0] a;
    exp_bus.delete();
    exp_tx.delete();
    if (frame[0] == 8'h57 || frame[0] == 8'h52) begin
      a      = {frame[1], frame[2], frame[3]};
      b.addr = a[20:0];
      b.wr   = (frame[0] == 8'h57);
      b.data = b.wr ? {frame[4], frame[5], frame[6], frame[7]} : 32'h0;
      exp_bus.push_back(b);
      if (b.wr) exp_tx.push_back(8'h4B);
      else for (int k = 3; k >= 0; k--) exp_tx.push_back(rd_word[8*k +: 8]);
    end else begin
      exp_tx.push_back(8'h3F);
    end
  endfunction

  function automatic void random_frame();
    logic [7:0] cmd;
    int         sel;
    frame.delete();
    sel = $urandom_range(0, 9);
    if (sel < 5) cmd = 8'h57;
    else if (sel < 9) cmd = 8'h52;
    else begin
      cmd = 8'($urandom);
      while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
    end
    frame.push_back(cmd);
    if (cmd == 8'h57 || cmd == 8'h52) repeat (3) frame.push_back(8'($urandom));
    if (cmd == 8'h57) repeat (4) frame.push_back(8'($urandom));
    rd_word = $urandom;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) step();
    total++;
    if ({tx_valid, mmio_cs, mmio_wr, mmio_rd, busy, overrun} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b, required 000000",
               {tx_valid, mmio_cs, mmio_wr, mmio_rd, busy, overrun});
    end
    total++;
    if (mmio_addr !== 21'h0) begin
      bad++;
      $display("[TB] FAIL reset_addr: got %h, required 0", mmio_addr);
    end
    total++;
    if (mmio_wr_data !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_wr_data: got %h, required 0", mmio_wr_data);
    end
    total++;
    if (tx_data !== 8'h0) begin
      bad++;
      $display("[TB] FAIL reset_tx_data: got %h, required 0", tx_data);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write();
    bit ok;
    clear_obs();
    ready_mode = 1;
    frame = '{8'h57, 8'h00, 8'h00, 8'hC4, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(1'b0);
    total++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL write_bus_timing: cs/wr/rd=%b, required 110", {mmio_cs, mmio_wr, mmio_rd});
    end
    wait_idle(ok);
    total++;
    if (!ok || got_bus.size() != 1 || got_bus[0] !== {1'b1, 21'h0000C4, 32'h12345678}) begin
      bad++;
      $display("[TB] FAIL write_bus: done=%0d count=%0d, required one write C4/12345678", ok, got_bus.size());
    end
    total++;
    if (got_tx.size() != 1 || got_tx[0] !== 8'h4B) begin
      bad++;
      $display("[TB] FAIL write_resp: count=%0d, required single byte 4B", got_tx.size());
    end
  endtask

  task automatic test_read();
    bit ok;
    clear_obs();
    ready_mode = 1;
    rd_word = 32'hDEADBEEF;
    frame = '{8'h52, 8'h00, 8'h01, 8'h00};
    send_frame(1'b0);
    total++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b101) begin
      bad++;
      $display("[TB] FAIL read_bus_timing: cs/wr/rd=%b, required 101", {mmio_cs, mmio_wr, mmio_rd});
    end
    wait_idle(ok);
    total++;
    if (!ok || got_bus.size() != 1 || got_bus[0] !== {1'b0, 21'h000100, 32'h0}) begin
      bad++;
      $display("[TB] FAIL read_bus: done=%0d count=%0d, required one read at 000100", ok, got_bus.size());
    end
    total++;
    if (got_tx.size() != 4 || {got_tx[0], got_tx[1], got_tx[2], got_tx[3]} !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL read_resp: count=%0d, required DE AD BE EF", got_tx.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_obs();
    ready_mode = 0;
    rd_word = 32'hDEADBEEF;
    frame = '{8'h52, 8'h00, 8'h01, 8'h00};
    send_frame(1'b0);
    for (int i = 0; i < 5 && !tx_valid; i++) step();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hDE) begin
        bad++;
        $display("[TB] FAIL stall_hold: cycle %0d valid=%b data=%h, required 1 DE", i, tx_valid, tx_data);
      end
      step();
    end
    ready_mode = 1;
    wait_idle(ok);
    total++;
    if (!ok || got_tx.size() != 4 || {got_tx[0], got_tx[1], got_tx[2], got_tx[3]} !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL stall_resp: done=%0d count=%0d, required DE AD BE EF", ok, got_tx.size());
    end
  endtask

  task automatic test_bad_cmd();
    bit ok;
    clear_obs();
    ready_mode = 2;
    frame = '{8'h41};
    send_frame(1'b0);
    wait_idle(ok);
    total++;
    if (!ok || got_bus.size() != 0) begin
      bad++;
      $display("[TB] FAIL bad_cmd_bus: done=%0d strobes=%0d, required 0 strobes", ok, got_bus.size());
    end
    total++;
    if (got_tx.size() != 1 || got_tx[0] !== 8'h3F) begin
      bad++;
      $display("[TB] FAIL bad_cmd_resp: count=%0d, required single byte 3F", got_tx.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_obs();
    ready_mode = 2;
    frame = '{8'h57, 8'h00};
    send_frame(1'b0);
    repeat (14) step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_early: busy=%b after 14 idle clocks, required 1", busy);
    end
    repeat (3) step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_late: busy=%b after 17 idle clocks, required 0", busy);
    end
    total++;
    if (got_bus.size() != 0 || got_tx.size() != 0) begin
      bad++;
      $display("[TB] FAIL timeout_silent: strobes=%0d tx=%0d, required 0 0", got_bus.size(), got_tx.size());
    end
    clear_obs();
    frame = '{8'h57, 8'h00, 8'h12, 8'h34, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    model_expect();
    send_frame(1'b1);
    wait_idle(ok);
    total++;
    if (!ok || got_bus.size() != 1 || got_bus[0] !== exp_bus[0] || got_tx.size() != 1 || got_tx[0] !== 8'h4B) begin
      bad++;
      $display("[TB] FAIL after_timeout: done=%0d strobes=%0d tx=%0d, required 1 1", ok, got_bus.size(), got_tx.size());
    end
  endtask

  task automatic test_overrun();
    bit ok;
    clear_obs();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overrun_initial: got %b, required 0", overrun);
    end
    ready_mode = 0;
    frame = '{8'h52, 8'h1F, 8'hFF, 8'hFC};
    rd_word = $urandom;
    model_expect();
    send_frame(1'b0);
    for (int i = 0; i < 5 && !tx_valid; i++) step();
    send_byte(8'h57);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL overrun_set: got %b, required 1", overrun);
    end
    ready_mode = 1;
    wait_idle(ok);
    repeat (3) step();
    total++;
    if (!ok || busy !== 1'b0 || got_bus.size() != 1 || got_bus[0] !== exp_bus[0]) begin
      bad++;
      $display("[TB] FAIL overrun_bus: done=%0d busy=%b strobes=%0d, required 1 0 1", ok, busy, got_bus.size());
    end
    total++;
    if (got_tx.size() != 4 || {got_tx[0], got_tx[1], got_tx[2], got_tx[3]} !== rd_word) begin
      bad++;
      $display("[TB] FAIL overrun_resp: count=%0d, required %h", got_tx.size(), rd_word);
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ready_mode = 2;
    for (int n = 0; n < 25; n++) begin
      clear_obs();
      random_frame();
      model_expect();
      send_frame(n[0]);
      wait_idle(ok);
      total++;
      if (!ok || got_bus.size() != exp_bus.size()) begin
        bad++;
        $display("[TB] FAIL b2b_bus_count: frame %0d done=%0d got %0d, required %0d",
                 n, ok, got_bus.size(), exp_bus.size());
      end else if (exp_bus.size() == 1 && got_bus[0] !== exp_bus[0]) begin
        bad++;
        $display("[TB] FAIL b2b_bus: frame %0d got %h, required %h", n, got_bus[0], exp_bus[0]);
      end
      total++;
      if (got_tx.size() != exp_tx.size()) begin
        bad++;
        $display("[TB] FAIL b2b_tx_count: frame %0d got %0d, required %0d", n, got_tx.size(), exp_tx.size());
      end else begin
        foreach (exp_tx[k]) begin
          if (got_tx[k] !== exp_tx[k]) begin
            bad++;
            $display("[TB] FAIL b2b_tx: frame %0d byte %0d got %h, required %h", n, k, got_tx[k], exp_tx[k]);
            break;
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_data();
    clear_obs();
    ready_mode = 1;
    frame = '{8'h57, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22};
    send_frame(1'b0);
    reset = 1'b1;
    step();
    total++;
    if ({tx_valid, mmio_cs, mmio_wr, mmio_rd, busy, overrun} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_flags: got %b, required 000000",
               {tx_valid, mmio_cs, mmio_wr, mmio_rd, busy, overrun});
    end
    total++;
    if (mmio_addr !== 21'h0 || mmio_wr_data !== 32'h0 || tx_data !== 8'h0) begin
      bad++;
      $display("[TB] FAIL mid_reset_data: addr=%h wd=%h tx=%h, required 0 0 0", mmio_addr, mmio_wr_data, tx_data);
    end
    reset = 1'b0;
    repeat (20) step();
    total++;
    if (got_bus.size() != 0 || got_tx.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_quiet: strobes=%0d tx=%0d busy=%b, required 0 0 0",
               got_bus.size(), got_tx.size(), busy);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    step();
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_bad_cmd();
    test_timeout();
    test_back_to_back();
    test_overrun();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_debug_bridge.md
MMIO_DEBUG_BRIDGE -- requirements
Module: mmio_debug_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1_000_000, maximum idle clocks allowed between bytes of one command frame.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle; there is no backpressure.
REQ-006 SHALL have port tx_data  output  8  response byte.
REQ-007 SHALL have port tx_valid  output  1  tx_data is offered.
REQ-008 SHALL have port tx_ready  input  1  the byte is accepted when tx_valid and tx_ready are both high.
REQ-009 SHALL have port mmio_cs  output  1  FPro bus chip select.
REQ-010 SHALL have port mmio_wr  output  1  FPro bus write strobe.
REQ-011 SHALL have port mmio_rd  output  1  FPro bus read strobe.
REQ-012 SHALL have port mmio_addr  output  21  FPro bus word address.
REQ-013 SHALL have port mmio_wr_data  output  32  FPro bus write data.
REQ-014 SHALL have port mmio_rd_data  input  32  FPro bus read data.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 SHALL have port overrun  output  1  sticky; set when an rx byte is dropped.

Function
REQ-017 Frame format SHALL be:
- command byte, then 3 address bytes (big-endian, bits [23:21] ignored);
- write command 0x57 'W': address is followed by 4 data bytes (big-endian);
- read command 0x52 'R': no data bytes.
REQ-018 FSM states SHALL be IDLE, ADDR, DATA, BUS, RESP.
REQ-019 IDLE transitions on rx_valid:
- 'W' or 'R' -> ADDR;
- any other byte -> RESP with the single response byte 0x3F '?'.
REQ-020 ADDR: after the 3rd address byte, 'W' -> DATA and 'R' -> BUS.
REQ-021 DATA: after the 4th data byte -> BUS.
REQ-022 BUS SHALL last exactly one cycle:
- mmio_cs=1, plus mmio_wr=1 for a write or mmio_rd=1 for a read;
- mmio_addr and mmio_wr_data stable;
- for a read, mmio_rd_data is captured at the closing clock edge of that cycle.
REQ-023 Outside BUS, mmio_cs, mmio_wr and mmio_rd SHALL be 0; mmio_wr and mmio_rd SHALL never be high together.
REQ-024 The BUS cycle SHALL begin the cycle after the final frame byte is strobed.
REQ-025 RESP SHALL send:
- write: one byte 0x4B 'K';
- read: 4 bytes, most significant byte first.
REQ-026 In RESP, tx_valid SHALL be high and tx_data stable until the handshake; the next byte is offered the cycle after the handshake; after the last handshake the FSM returns to IDLE.
REQ-027 An idle counter SHALL clear on each rx_valid while in ADDR or DATA.
REQ-028 When the idle counter reaches TIMEOUT_CYC, the FSM SHALL go to IDLE, discard the frame, perform no bus access and send no response.
REQ-029 An rx_valid in BUS or RESP SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-030 Byte counters SHALL be 2 bits and SHALL clear on every state entry.

Reset
REQ-031 Reset SHALL force:
- FSM to IDLE; counters and shift registers to 0;
- tx_valid, mmio_cs, mmio_wr, mmio_rd, busy and overrun to 0;
- mmio_addr, mmio_wr_data and tx_data to 0.
REQ-032 Reset asserted mid-frame or mid-response SHALL abandon the operation with no bus strobe and no further tx bytes.

Structure
REQ-033 A package mmio_bridge_pkg SHALL hold:
- the state enum;
- command/response byte constants 0x57, 0x52, 0x4B, 0x3F;
- frame length constants.
REQ-034 The response serializer SHALL be the sub-module bridge_tx_ser: 32-bit load, byte count 1 or 4, valid/ready output.

Verification
REQ-035 Write frame 57 00 00 C4 12 34 56 78 -> one cycle of cs=1, wr=1, addr=0x0000C4, wr_data=0x12345678; tx sends 0x4B.
REQ-036 Read frame 52 00 01 00 with mmio_rd_data=0xDEADBEEF -> one cycle of cs=1, rd=1, addr=0x000100; tx sends DE AD BE EF in order.
REQ-037 tx_ready held low for 10 cycles during a read response -> tx_data remains 0xDE with tx_valid high; no byte is lost or duplicated.
REQ-038 Byte 0x41 in IDLE -> tx sends 0x3F; no bus strobe occurs.
REQ-039 TIMEOUT_CYC=16, then send 57 00 and wait 16 cycles -> busy falls and no bus access occurs; a following full frame completes normally.
REQ-040 rx_valid during RESP -> overrun=1 and the response is unaffected; reset mid-DATA -> all outputs are 0 and no strobe occurs.
